// File: rtl/pia_ctrl_pkg.sv
// rtl/pia_ctrl_pkg.sv - shared state encoding, register-select codes and chip-select default for pia_ctrl
package pia_ctrl_pkg;

  typedef enum logic [3:0] {
    INIT_CRA0,
    INIT_DDRA,
    INIT_CRA,
    INIT_CRB0,
    INIT_DDRB,
    INIT_CRB,
    IDLE,
    RX_RD,
    TX_WR,
    TX_WAIT,
    TX_CLR
  } state_t;

  localparam logic [1:0] RS_PRA_DDRA = 2'b00;
  localparam logic [1:0] RS_CRA      = 2'b01;
  localparam logic [1:0] RS_PRB_DDRB = 2'b10;
  localparam logic [1:0] RS_CRB      = 2'b11;

  localparam logic [2:0] CS_SEL_DEFAULT = 3'b011;

endpackage

// File: rtl/pia_ctrl_timer.sv
// rtl/pia_ctrl_timer.sv - cycle counter bounding the wait for the CB1 acknowledge
module pia_ctrl_timer #(
  parameter logic [15:0] TX_TIMEOUT = 16'd1000
) (
  input  logic enable,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired,
  output logic running
);

  logic [15:0] timer;

  always_ff @(posedge enable) begin
    if (reset || clear) begin
      timer <= 16'd0;
    end else if (count) begin
      timer <= timer + 16'd1;
    end
  end

  // expired flags the TX_TIMEOUT-th counted cycle, so the wait lasts exactly that long
  assign expired = count && (timer == TX_TIMEOUT - 16'd1);
  assign running = (timer != 16'd0);

endmodule

// File: rtl/pia_ctrl.sv
// rtl/pia_ctrl.sv - 6821 PIA sequencer: init writes, port-A receive stream, port-B transmit with CB1 acknowledge
module pia_ctrl
  import pia_ctrl_pkg::*;
#(
  parameter logic [2:0]  CS_SEL     = CS_SEL_DEFAULT,
  parameter logic [7:0]  CRA_INIT   = 8'h05,
  parameter logic [7:0]  CRB_INIT   = 8'h05,
  parameter logic [7:0]  DDRA_INIT  = 8'h00,
  parameter logic [7:0]  DDRB_INIT  = 8'hFF,
  parameter logic [15:0] TX_TIMEOUT = 16'd1000
) (
  input  logic       enable,
  input  logic       reset,
  output logic [2:0] pia_cs,
  output logic [1:0] pia_rs,
  output logic       pia_rw,
  output logic [7:0] pia_di,
  input  logic [7:0] pia_do,
  input  logic       pia_irqa_n,
  input  logic       pia_irqb_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       init_done,
  output logic       tx_timeout
);

  state_t     state, nxt;
  logic       launched;
  logic       acc, nrw;
  logic [1:0] nrs;
  logic [7:0] ndi;
  logic       rx_sel, tx_fire;
  logic       expired, running;

  assign rx_sel   = (state == IDLE) && !pia_irqa_n && !rx_valid;
  assign tx_ready = (state == IDLE) && init_done && !rx_sel;
  assign tx_fire  = tx_valid && tx_ready;

  pia_ctrl_timer #(.TX_TIMEOUT(TX_TIMEOUT)) u_timer (
    .enable  (enable),
    .reset   (reset),
    .clear   (state != TX_WAIT),
    .count   (state == TX_WAIT),
    .expired (expired),
    .running (running)
  );

  always_comb begin
    nxt = state;
    case (state)
      // first post-reset cycle leaves the bus idle; the CRA clear goes out on the next one
      INIT_CRA0: nxt = launched ? INIT_DDRA : INIT_CRA0;
      INIT_DDRA: nxt = INIT_CRA;
      INIT_CRA:  nxt = INIT_CRB0;
      INIT_CRB0: nxt = INIT_DDRB;
      INIT_DDRB: nxt = INIT_CRB;
      INIT_CRB:  nxt = IDLE;
      IDLE: begin
        if (rx_sel)       nxt = RX_RD;
        else if (tx_fire) nxt = TX_WR;
      end
      RX_RD:   nxt = IDLE;
      TX_WR:   nxt = TX_WAIT;
      TX_WAIT: begin
        if (running && !pia_irqb_n) nxt = TX_CLR;
        else if (expired)           nxt = IDLE;
      end
      TX_CLR:  nxt = IDLE;
      default: nxt = INIT_CRA0;
    endcase

    // bus outputs are registered from the state being entered, so each access owns that state's cycle
    acc = 1'b1;
    nrs = RS_PRA_DDRA;
    nrw = 1'b0;
    ndi = 8'h00;
    case (nxt)
      INIT_CRA0: nrs = RS_CRA;
      INIT_DDRA: ndi = DDRA_INIT;
      INIT_CRA:  begin nrs = RS_CRA;      ndi = CRA_INIT;  end
      INIT_CRB0: nrs = RS_CRB;
      INIT_DDRB: begin nrs = RS_PRB_DDRB; ndi = DDRB_INIT; end
      INIT_CRB:  begin nrs = RS_CRB;      ndi = CRB_INIT;  end
      RX_RD:     nrw = 1'b1;
      TX_WR:     begin nrs = RS_PRB_DDRB; ndi = tx_data;   end
      TX_CLR:    begin nrs = RS_PRB_DDRB; nrw = 1'b1;      end
      default:   begin acc = 1'b0;        nrw = 1'b1;      end
    endcase
  end

  always_ff @(posedge enable) begin
    if (reset) begin
      state      <= INIT_CRA0;
      launched   <= 1'b0;
      pia_cs     <= 3'b000;
      pia_rs     <= 2'b00;
      pia_rw     <= 1'b1;
      pia_di     <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      init_done  <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state      <= nxt;
      launched   <= 1'b1;
      pia_cs     <= acc ? CS_SEL : 3'b000;
      pia_rs     <= nrs;
      pia_rw     <= nrw;
      pia_di     <= ndi;
      tx_timeout <= (state == TX_WAIT) && (nxt == IDLE);
      if (nxt == IDLE) init_done <= 1'b1;
      if (state == RX_RD) begin
        rx_data  <= pia_do;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pia_ctrl.sv
// tb/tb_pia_ctrl.sv - directed self-checking bench for pia_ctrl with a behavioural PIA model
module tb_pia_ctrl;

  logic       enable = 1'b0;
  logic       reset;
  logic [2:0] pia_cs;
  logic [1:0] pia_rs;
  logic       pia_rw;
  logic [7:0] pia_di, pia_do;
  logic       pia_irqa_n, pia_irqb_n;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic       init_done, tx_timeout;

  always #5 enable = ~enable;

  pia_ctrl #(.TX_TIMEOUT(16'd16)) dut (
    .enable     (enable),
    .reset      (reset),
    .pia_cs     (pia_cs),
    .pia_rs     (pia_rs),
    .pia_rw     (pia_rw),
    .pia_di     (pia_di),
    .pia_do     (pia_do),
    .pia_irqa_n (pia_irqa_n),
    .pia_irqb_n (pia_irqb_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .init_done  (init_done),
    .tx_timeout (tx_timeout)
  );

  // PIA model: an edge request raises the flag; the matching port read clears it
  int ca1_req = 0, ca1_clr = 0, cb1_req = 0, cb1_clr = 0;
  logic [7:0] pai = 8'h00;
  assign pia_irqa_n = (ca1_req == ca1_clr);
  assign pia_irqb_n = (cb1_req == cb1_clr);
  assign pia_do     = (pia_rs == 2'b00) ? pai : 8'hEE;

  int cyc = 0;
  int pra_reads = 0, prb_reads = 0, prb_writes = 0, timeouts = 0;
  int pra_cycle = 0, prb_wr_cycle = 0, timeout_cycle = 0;
  logic [7:0] prb_di = 8'h00;

  always @(posedge enable) cyc++;

  always @(negedge enable) begin
    if (pia_cs != 3'b000) begin
      if (pia_rw) begin
        if (pia_rs == 2'b00) begin
          pra_reads++;
          pra_cycle = cyc;
          ca1_clr = ca1_req;
        end else if (pia_rs == 2'b10) begin
          prb_reads++;
          cb1_clr = cb1_req;
        end
      end else if (pia_rs == 2'b10) begin
        prb_writes++;
        prb_di = pia_di;
        prb_wr_cycle = cyc;
      end
    end
    if (tx_timeout) begin
      timeouts++;
      timeout_cycle = cyc;
    end
  end

  typedef struct {
    logic [2:0] cs;
    logic [1:0] rs;
    logic       rw;
    logic [7:0] di;
    logic       done;
    logic       txr;
  } vec_t;

  vec_t init_tbl[8];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // entered #1 after the first edge with reset low, i.e. in cycle 0
  task automatic run_init_table();
    for (int i = 0; i < 8; i++) begin
      @(negedge enable);
      chk($sformatf("init[%0d].cs", i), {29'd0, pia_cs}, {29'd0, init_tbl[i].cs});
      chk($sformatf("init[%0d].rs", i), {30'd0, pia_rs}, {30'd0, init_tbl[i].rs});
      chk($sformatf("init[%0d].rw", i), {31'd0, pia_rw}, {31'd0, init_tbl[i].rw});
      chk($sformatf("init[%0d].di", i), {24'd0, pia_di}, {24'd0, init_tbl[i].di});
      chk($sformatf("init[%0d].init_done", i), {31'd0, init_done}, {31'd0, init_tbl[i].done});
      chk($sformatf("init[%0d].tx_ready", i), {31'd0, tx_ready}, {31'd0, init_tbl[i].txr});
      if (i == 0) begin
        chk("reset.rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset.rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset.tx_timeout", {31'd0, tx_timeout}, 32'd0);
      end
    end
  endtask

  task automatic consume_rx();
    @(posedge enable); #1 rx_ready = 1'b1;
    @(posedge enable); #1 rx_ready = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] d);
    int k;
    tx_data  = d;
    tx_valid = 1'b1;
    for (k = 0; k < 10 && !tx_ready; k++) @(negedge enable);
    chk("tx_handshake", {31'd0, tx_ready}, 32'd1);
    @(posedge enable); #1 tx_valid = 1'b0;
  endtask

  task automatic wait_prb_write(input int base);
    for (int k = 0; k < 10 && prb_writes == base; k++) @(negedge enable);
    chk("prb_write_count", prb_writes - base, 32'd1);
  endtask

  initial begin
    int base_pra, base_prb_w, base_prb_r, base_to;
    init_tbl[0] = '{3'b000, 2'b00, 1'b1, 8'h00, 1'b0, 1'b0};
    init_tbl[1] = '{3'b011, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
    init_tbl[2] = '{3'b011, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    init_tbl[3] = '{3'b011, 2'b01, 1'b0, 8'h05, 1'b0, 1'b0};
    init_tbl[4] = '{3'b011, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0};
    init_tbl[5] = '{3'b011, 2'b10, 1'b0, 8'hFF, 1'b0, 1'b0};
    init_tbl[6] = '{3'b011, 2'b11, 1'b0, 8'h05, 1'b0, 1'b0};
    init_tbl[7] = '{3'b000, 2'b00, 1'b1, 8'h00, 1'b1, 1'b1};

    reset = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge enable);
    #1 reset = 1'b0;
    run_init_table();

    // single CA1 edge -> one PRA read
    @(posedge enable); #1;
    pai = 8'h41; base_pra = pra_reads; ca1_req++;
    for (int k = 0; k < 10 && !rx_valid; k++) @(negedge enable);
    chk("rx1.rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx1.reads", pra_reads - base_pra, 32'd1);
    chk("rx1.rx_data", {24'd0, rx_data}, 32'h41);
    chk("rx1.irqa_n", {31'd0, pia_irqa_n}, 32'd1);

    // second edge held off while rx_valid is set
    pai = 8'h42;
    @(posedge enable); #1 ca1_req++;
    repeat (6) @(negedge enable);
    chk("rx2.no_read", pra_reads - base_pra, 32'd1);
    chk("rx2.held_data", {24'd0, rx_data}, 32'h41);
    chk("rx2.irq_pending", {31'd0, pia_irqa_n}, 32'd0);
    consume_rx();
    for (int k = 0; k < 10 && !rx_valid; k++) @(negedge enable);
    chk("rx2.rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx2.reads", pra_reads - base_pra, 32'd2);
    chk("rx2.rx_data", {24'd0, rx_data}, 32'h42);
    consume_rx();
    chk("rx2.cleared", {31'd0, rx_valid}, 32'd0);

    // tx with CB1 acknowledge five cycles after the PRB write
    base_prb_w = prb_writes; base_prb_r = prb_reads; base_to = timeouts;
    send_tx(8'h8D);
    wait_prb_write(base_prb_w);
    chk("tx1.prb_di", {24'd0, prb_di}, 32'h8D);
    repeat (5) @(posedge enable);
    #1 cb1_req++;
    for (int k = 0; k < 10 && prb_reads == base_prb_r; k++) @(negedge enable);
    chk("tx1.clear_read", prb_reads - base_prb_r, 32'd1);
    @(negedge enable);
    chk("tx1.tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("tx1.irqb_n", {31'd0, pia_irqb_n}, 32'd1);
    chk("tx1.no_timeout", timeouts - base_to, 32'd0);

    // tx without acknowledge -> timeout; a CA1 edge during TX_WAIT waits for IDLE
    pai = 8'h5C;
    base_prb_w = prb_writes; base_prb_r = prb_reads; base_to = timeouts; base_pra = pra_reads;
    @(posedge enable); #1;
    send_tx(8'h5A);
    wait_prb_write(base_prb_w);
    repeat (3) @(posedge enable);
    #1 ca1_req++;
    for (int k = 0; k < 30 && timeouts == base_to; k++) @(negedge enable);
    chk("to.pulse_seen", timeouts - base_to, 32'd1);
    chk("to.latency", timeout_cycle - prb_wr_cycle, 32'd17);
    chk("to.no_clear_read", prb_reads - base_prb_r, 32'd0);
    chk("to.no_rx_in_wait", pra_reads - base_pra, 32'd0);
    for (int k = 0; k < 10 && !rx_valid; k++) @(negedge enable);
    chk("to.rx_after_idle", pra_cycle - timeout_cycle, 32'd1);
    chk("to.rx_data", {24'd0, rx_data}, 32'h5C);
    @(negedge enable);
    chk("to.pulse_width", timeouts - base_to, 32'd1);
    chk("to.tx_timeout_low", {31'd0, tx_timeout}, 32'd0);
    consume_rx();

    // rx and tx requested in the same IDLE cycle: rx served first
    pai = 8'h77;
    base_prb_w = prb_writes;
    @(posedge enable); #1;
    ca1_req++; tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge enable);
    chk("prio.tx_ready_low", {31'd0, tx_ready}, 32'd0);
    send_tx(8'h3C);
    wait_prb_write(base_prb_w);
    chk("prio.rx_first", {31'd0, pra_cycle < prb_wr_cycle}, 32'd1);
    chk("prio.rx_data", {24'd0, rx_data}, 32'h77);
    chk("prio.prb_di", {24'd0, prb_di}, 32'h3C);

    // reset in TX_WAIT reruns init and drops the held byte
    base_to = timeouts;
    @(posedge enable); #1 reset = 1'b1;
    @(posedge enable); #1 reset = 1'b0;
    run_init_table();
    repeat (20) @(negedge enable);
    chk("rst.no_timeout", timeouts - base_to, 32'd0);
    chk("rst.rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst.tx_ready", {31'd0, tx_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pia_ctrl.md
PIA_CTRL -- requirements
Module: pia_ctrl

Interface
REQ-001 Parameter CS_SEL, default 3'b011, is the chip-select pattern that selects the PIA.
REQ-002 Parameter CRA_INIT, default 8'h05, is the CRA value written at init: CA1 falling-edge IRQ enabled, peripheral register selected.
REQ-003 Parameter CRB_INIT, default 8'h05, is the CRB value written at init.
REQ-004 Parameter DDRA_INIT, default 8'h00, makes port A all inputs.
REQ-005 Parameter DDRB_INIT, default 8'hFF, makes port B all outputs.
REQ-006 Parameter TX_TIMEOUT, default 16'd1000, is the maximum number of cycles to wait for the CB1 acknowledge.
REQ-007 enable  in  1  sole clock; all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 pia_cs  out  3  PIA chip select; CS_SEL only during an access cycle, otherwise 3'b000.
REQ-010 pia_rs  out  2  PIA register select.
REQ-011 pia_rw  out  1  1 = read, 0 = write.
REQ-012 pia_di  out  8  write data to the PIA.
REQ-013 pia_do  in  8  read data from the PIA.
REQ-014 pia_irqa_n, pia_irqb_n  in  1 each  PIA interrupt lines, active low.
REQ-015 rx_data  out  8, rx_valid  out  1, rx_ready  in  1  port-A byte stream.
REQ-016 tx_data  in  8, tx_valid  in  1, tx_ready  out  1  port-B byte stream.
REQ-017 init_done  out  1  high once the init sequence has completed.
REQ-018 tx_timeout  out  1  one-cycle pulse when an acknowledge is missed.

Function
REQ-019 Each PIA access shall occupy exactly one cycle with pia_cs=CS_SEL and rs/rw/di registered and stable; read data shall be sampled from pia_do at the edge ending that cycle.
REQ-020 The FSM states shall be INIT_CRA0, INIT_DDRA, INIT_CRA, INIT_CRB0, INIT_DDRB, INIT_CRB, IDLE, RX_RD, TX_WR, TX_WAIT and TX_CLR.
REQ-021 The init sequence shall run one write per cycle, in order: CRA<=00, DDRA<=DDRA_INIT, CRA<=CRA_INIT, CRB<=00, DDRB<=DDRB_INIT, CRB<=CRB_INIT (rs 01,00,01,11,10,11); the FSM then enters IDLE.
REQ-022 init_done shall rise in the cycle IDLE is first entered, which is the 7th cycle after reset deasserts, and shall stay high until the next reset.
REQ-023 In IDLE, if pia_irqa_n=0 and rx_valid=0, the FSM shall go to RX_RD; this has priority over tx.
REQ-024 RX_RD shall read PRA (rs=00, rw=1), load rx_data, set rx_valid the next cycle, and return to IDLE.
REQ-025 rx_valid shall clear on the cycle after rx_valid and rx_ready are both high; while rx_valid=1, no PRA read shall occur and the IRQ shall remain pending in the PIA.
REQ-026 tx_ready shall be 1 only in IDLE with init_done=1 and no RX service selected that cycle.
REQ-027 A tx_valid and tx_ready handshake shall latch tx_data and enter TX_WR, which writes PRB (rs=10, rw=0, di=latched byte), then enters TX_WAIT.
REQ-028 TX_WAIT shall ignore pia_irqb_n in its first cycle.
REQ-029 In TX_WAIT, pia_irqb_n=0 shall lead to TX_CLR, which reads PRB to clear the CB1 flag (data discarded) and returns to IDLE.
REQ-030 If TX_WAIT lasts TX_TIMEOUT cycles, tx_timeout shall pulse for one cycle and the FSM shall return to IDLE with no clear read.
REQ-031 pia_irqa_n shall not be serviced outside IDLE.
REQ-032 No PIA read shall be issued except in RX_RD and TX_CLR.

Reset
REQ-033 Reset shall force pia_cs=000, pia_rs=00, pia_rw=1, pia_di=00, rx_data=00, rx_valid=0, tx_ready=0, init_done=0, tx_timeout=0, timer=0 and state INIT_CRA0.
REQ-034 A reset during any state, including mid-transfer, shall drop the held rx byte and the latched tx byte and rerun the full init sequence.

Structure
REQ-035 Package pia_ctrl_pkg shall hold the state enum, the RS encodings (PRA_DDRA=00, CRA=01, PRB_DDRB=10, CRB=11) and the default CS_SEL.
REQ-036 The TX_WAIT cycle counter shall be sub-module pia_ctrl_timer (clear, count, expired at TX_TIMEOUT).

Verification
REQ-037 Release reset -> six writes in cycles 1-6: rs/di = 01/00, 00/00, 01/05, 11/00, 10/FF, 11/05, all with cs=011 and rw=0; init_done=1 at cycle 7.
REQ-038 After init, PIA model PAI=8'h41 and a CA1 falling edge (irqa_n low) -> one read at rs=00; rx_data=41 and rx_valid=1; irqa_n returns high.
REQ-039 Hold rx_ready=0 and send a second CA1 edge -> no PRA read while rx_valid=1; after rx_ready=1 for one cycle, the pending IRQ is read.
REQ-040 tx_data=8'h8D with tx_valid=1 -> PRB write of 8D; CB1 pulse after 5 cycles -> clear read at rs=10; back to IDLE; tx_ready=1.
REQ-041 tx with no CB1 pulse and TX_TIMEOUT=16 -> tx_timeout pulse 16 cycles after TX_WAIT is entered; no rs=10 read occurs.
REQ-042 irqa_n low and tx_valid high in the same IDLE cycle -> RX_RD first, then tx accepted; assert reset in TX_WAIT -> init rerun and rx_valid=0.
